// File: rtl/port_pkg.sv
// Shared register map and reset constants for the bidirectional GPIO port.
`timescale 1ns/1ps
package port_pkg;

   localparam logic [2:0] ADDR_DATA       = 3'd0;
   localparam logic [2:0] ADDR_CONFIG     = 3'd1;
   localparam logic [2:0] ADDR_ENABLE     = 3'd2;
   localparam logic [2:0] ADDR_IRQ_EN     = 3'd3;
   localparam logic [2:0] ADDR_IRQ_STATUS = 3'd4;

   // Wide enough for any supported WIDTH; slice to the port width at use.
   localparam logic [63:0] CONFIG_RST = '1;

endpackage

// File: rtl/port_debounce_bit.sv
// One-bit debounce filter: output follows the input only after DEB_SAMPLES
// consecutive ticks of disagreement.
`timescale 1ns/1ps
module port_debounce_bit #(
   parameter int unsigned DEB_SAMPLES = 3
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic tick,
   input  logic din,
   output logic dout
);

   logic [2:0] cnt_q, cnt_d;
   logic       dout_q, dout_d;

   always_comb begin
      cnt_d  = cnt_q;
      dout_d = dout_q;
      if (din == dout_q) begin
         cnt_d = '0;
      end else if (tick) begin
         if (cnt_q == 3'(DEB_SAMPLES - 1)) begin
            dout_d = ~dout_q;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_q + 3'd1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         dout_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/bidirectional_port.sv
// Memory-mapped GPIO port with tristate pads, synchronized inputs, rising-edge
// interrupts and an optional debounce filter enabled by PORT_DEBOUNCE_EN.
`timescale 1ns/1ps
module bidirectional_port
   import port_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEB_DIV     = 50000,
   parameter int unsigned DEB_SAMPLES = 3
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic             wr,
   input  logic [2:0]       reg_addr,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             irq,
   inout  wire  [WIDTH-1:0] port_io
);

   if (DEB_SAMPLES < 2 || DEB_SAMPLES > 7 || DEB_DIV < 1) begin : g_bad_cfg
      $error("bidirectional_port: DEB_SAMPLES must be 2..7 and DEB_DIV >= 1");
   end

   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] cfg_q, cfg_d;
   logic [WIDTH-1:0] en_q, en_d;
   logic [WIDTH-1:0] ien_q, ien_d;
   logic [WIDTH-1:0] ists_q, ists_d;
   logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
   logic [WIDTH-1:0] deb, rise, clr;
   logic             irq_q;

   always_comb begin
      out_d = out_q;
      cfg_d = cfg_q;
      en_d  = en_q;
      ien_d = ien_q;
      clr   = '0;
      if (ce && wr) begin
         case (reg_addr)
            ADDR_DATA:       out_d = data_in;
            ADDR_CONFIG:     cfg_d = data_in;
            ADDR_ENABLE:     en_d  = data_in;
            ADDR_IRQ_EN:     ien_d = data_in;
            ADDR_IRQ_STATUS: clr   = data_in;
            default:         ;
         endcase
      end
      // Set dominates a same-cycle W1C so no edge is ever lost.
      rise   = deb & ~prev_q & cfg_q & en_q;
      ists_d = (ists_q & ~clr) | rise;
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         cfg_q   <= CONFIG_RST[WIDTH-1:0];
         en_q    <= '0;
         ien_q   <= '0;
         ists_q  <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         irq_q   <= 1'b0;
      end else begin
         out_q   <= out_d;
         cfg_q   <= cfg_d;
         en_q    <= en_d;
         ien_q   <= ien_d;
         ists_q  <= ists_d;
         sync1_q <= port_io;
         sync2_q <= sync1_q;
         prev_q  <= deb;
         irq_q   <= |(ists_q & ien_q);
      end
   end

`ifdef PORT_DEBOUNCE_EN
   localparam int unsigned PW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

   logic [PW-1:0] pre_q;
   logic          tick;

   assign tick = (pre_q == PW'(DEB_DIV - 1));

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) pre_q <= '0;
      else        pre_q <= tick ? '0 : pre_q + 1'b1;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_deb
      port_debounce_bit #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
         .sys_clk (sys_clk),
         .rst_n   (rst_n),
         .tick    (tick),
         .din     (sync2_q[i]),
         .dout    (deb[i])
      );
   end
`else
   assign deb = sync2_q;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_pad
      assign port_io[i] = (en_q[i] && !cfg_q[i]) ? out_q[i] : 1'bz;
   end

   always_comb begin
      data_out = '0;
      if (ce) begin
         case (reg_addr)
            ADDR_DATA:       data_out = ((cfg_q & deb) | (~cfg_q & out_q)) & en_q;
            ADDR_CONFIG:     data_out = cfg_q;
            ADDR_ENABLE:     data_out = en_q;
            ADDR_IRQ_EN:     data_out = ien_q;
            ADDR_IRQ_STATUS: data_out = ists_q;
            default:         data_out = '0;
         endcase
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_bidirectional_port.sv
// Directed bench for bidirectional_port; debounce vectors run when PORT_DEBOUNCE_EN is set.
`timescale 1ns/1ps
module tb_bidirectional_port;

   localparam logic [2:0] A_DATA = 3'd0, A_CFG = 3'd1, A_EN = 3'd2, A_IEN = 3'd3, A_STS = 3'd4;

   logic        sys_clk = 1'b0;
   logic        rst_n;
   logic        ce, wr;
   logic [2:0]  reg_addr;
   logic [31:0] data_in, data_out;
   logic        irq;
   wire  [31:0] port_io;
   logic [31:0] tb_en, tb_val;
   logic [31:0] v;
   int          n_chk = 0;
   int          n_pass = 0;

   for (genvar k = 0; k < 32; k++) begin : g_drv
      assign port_io[k] = tb_en[k] ? tb_val[k] : 1'bz;
   end

   bidirectional_port #(.WIDTH(32), .DEB_DIV(4), .DEB_SAMPLES(3)) dut (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .ce       (ce),
      .wr       (wr),
      .reg_addr (reg_addr),
      .data_in  (data_in),
      .data_out (data_out),
      .irq      (irq),
      .port_io  (port_io)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
      ce = 1'b1; wr = 1'b1; reg_addr = a; data_in = d;
      @(negedge sys_clk);
      ce = 1'b0; wr = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      ce = 1'b1; wr = 1'b0; reg_addr = a;
      #1 d = data_out;
      ce = 1'b0;
   endtask

   // Counts pad bits actually driven high; floating bits never read as 1.
   function automatic int ones_hi(input logic [31:0] p, input logic [31:0] m);
      int c = 0;
      for (int i = 0; i < 32; i++) if (m[i] && p[i] === 1'b1) c++;
      return c;
   endfunction

   initial begin
      rst_n = 1'b0; ce = 1'b0; wr = 1'b0; reg_addr = '0; data_in = '0;
      tb_en = '0; tb_val = '0;

      #45;
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_pad", ones_hi(port_io, 32'hFFFF_FFFF), 32'd0);
      rd(A_CFG, v);  chk("rst_cfg", v, 32'hFFFF_FFFF);
      rd(A_DATA, v); chk("rst_data", v, 32'd0);
      rd(A_STS, v);  chk("rst_sts", v, 32'd0);
      @(negedge sys_clk);
      rst_n = 1'b1;
      cyc(1);

      wr_reg(A_CFG, 32'hFFFF_FFF8);
      wr_reg(A_EN, 32'h7);
      wr_reg(A_DATA, 32'h5);
      chk("drv_pad", {29'd0, port_io[2:0]}, 32'h5);
      chk("drv_hiz", ones_hi(port_io, 32'hFFFF_FFF8), 32'd0);
      rd(A_DATA, v); chk("drv_data", v, 32'h5);

      // Bit 3 is an output but disabled: must float despite out_reg = 1.
      wr_reg(A_CFG, 32'hFFFF_FFF0);
      wr_reg(A_DATA, 32'hFFFF_FFFD);
      chk("drv2_pad", {29'd0, port_io[2:0]}, 32'h5);
      chk("drv2_hiz", ones_hi(port_io, 32'hFFFF_FFF8), 32'd0);
      rd(A_DATA, v); chk("drv2_data", v, 32'h5);

      wr_reg(A_CFG, 32'hFFFF_FFFF);
      wr_reg(A_DATA, 32'h0);
      tb_en = 32'h7; tb_val = 32'h0;
      cyc(4);

`ifndef PORT_DEBOUNCE_EN
      wr_reg(A_IEN, 32'h4);
      cyc(2);
      tb_val = 32'h4;
      cyc(1);
      rd(A_DATA, v); chk("lat1", v, 32'h0);
      cyc(1);
      rd(A_DATA, v); chk("lat2", v, 32'h4);
      rd(A_STS, v);  chk("sts_pre", v, 32'h0);
      cyc(1);
      rd(A_STS, v);  chk("sts_set", v, 32'h4);
      chk("irq_pre", {31'd0, irq}, 32'd0);
      cyc(1);
      chk("irq_set", {31'd0, irq}, 32'd1);

      wr_reg(A_STS, 32'h4);
      rd(A_STS, v);  chk("w1c_sts", v, 32'h0);
      cyc(1);
      chk("w1c_irq", {31'd0, irq}, 32'd0);

      tb_val = 32'h0;
      cyc(4);
      tb_val = 32'h4;
      cyc(2);
      wr_reg(A_STS, 32'h4);
      rd(A_STS, v);  chk("set_wins", v, 32'h4);

      // Turn bit 2 into an output: status kept, pad now driven by out_reg.
      tb_en = 32'h3;
      wr_reg(A_CFG, 32'hFFFF_FFFB);
      wr_reg(A_DATA, 32'h4);
      cyc(3);
      rd(A_STS, v);  chk("recfg_sts", v, 32'h4);
      chk("recfg_pad", {31'd0, port_io[2]}, 32'd1);
`else
      wr_reg(A_EN, 32'h1);
      begin
         int bad = 0;
         for (int r = 0; r < 6; r++) begin
            tb_val[0] = 1'b1;
            for (int c = 0; c < 6; c++) begin cyc(1); rd(A_DATA, v); if (v[0]) bad++; end
            tb_val[0] = 1'b0;
            for (int c = 0; c < 6; c++) begin cyc(1); rd(A_DATA, v); if (v[0]) bad++; end
         end
         chk("deb_glitch", bad, 32'd0);
      end
      begin
         int seen = 0;
         tb_val[0] = 1'b1;
         for (int c = 0; c < 20; c++) begin
            cyc(1);
            rd(A_DATA, v);
            if (c < 18 && v[0]) seen = 1;
         end
         chk("deb_hold", seen, 32'd1);
         chk("deb_final", v, 32'h1);
      end
`endif

      wr_reg(A_EN, 32'h0);
      wr_reg(A_CFG, 32'hFFFF_FFFF);
      wr_reg(A_STS, 32'hFFFF_FFFF);
      tb_en = 32'h3; tb_val = 32'h0;
      cyc(4);
      tb_val = 32'h2;
      cyc(20);
      rd(A_DATA, v); chk("dis_data", v, 32'h0);
      rd(A_STS, v);  chk("dis_sts", v, 32'h0);

      rd(3'd6, v);   chk("addr6_rd", v, 32'h0);
      wr_reg(3'd5, 32'h0);
      rd(A_CFG, v);  chk("addr5_wr", v, 32'hFFFF_FFFF);
      ce = 1'b0; reg_addr = A_CFG;
      #1 chk("ce_off", data_out, 32'h0);

      @(negedge sys_clk);
      ce = 1'b1; wr = 1'b1; reg_addr = A_EN; data_in = 32'hFF;
      #2 rst_n = 1'b0;
      @(posedge sys_clk);
      #1 ce = 1'b0; wr = 1'b0;
      @(negedge sys_clk);
      rst_n = 1'b1;
      rd(A_EN, v);   chk("rst_abort", v, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bidirectional_port.md
Name: bidirectional_port

Overview:
- Memory-mapped 32-bit GPIO peripheral on the processor side of the `port_io` pad bus of the MIPS microcontroller.
- External drivers (buttons, switches) and the core's load/store path meet here.
- Drives output bits onto `port_io` and samples input bits through a synchronizer and optional debounce filter.
- Raises an interrupt request on rising edges of enabled input bits.
- Register file is read combinationally, so the monocycle datapath completes a load in one cycle.

Parameters:
- `WIDTH`, 32, number of port bits.
- `DEB_DIV`, 50000, `sys_clk` cycles per debounce sample tick.
- `DEB_SAMPLES`, 3, consecutive identical ticks before a debounced bit changes (2..7).

Ports:
- `sys_clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ce`  in  1  chip enable from address decoder.
- `wr`  in  1  write strobe, qualified by `ce`.
- `reg_addr`  in  3  register select: 0 DATA, 1 CONFIG, 2 ENABLE, 3 IRQ_EN, 4 IRQ_STATUS.
- `data_in`  in  WIDTH  write data.
- `data_out`  out  WIDTH  read data (combinational).
- `irq`  out  1  interrupt request, level.
- `port_io`  inout  WIDTH  pad bus.

Behaviour:
- Reset (`rst_n` = 0, asynchronous):
  - `out_reg` = 0, CONFIG = all ones (all inputs), ENABLE = 0, IRQ_EN = 0, IRQ_STATUS = 0.
  - Synchronizer, filter and prescaler cleared; debounced value = 0.
  - `irq` = 0; `port_io` is all Z.
  - Reset asserted mid-transaction aborts any pending write.
- Pad drive:
  - `port_io[i]` = `out_reg[i]` when ENABLE[i] = 1 and CONFIG[i] = 0, else Z.
  - CONFIG bit meaning: 1 = input, 0 = output.
- Writes:
  - Take effect on the rising edge where `ce` & `wr`.
  - DATA writes `out_reg` for all bits.
  - CONFIG, ENABLE and IRQ_EN load directly.
  - IRQ_STATUS is write-1-to-clear.
  - `reg_addr` 5..7: write ignored.
- Reads:
  - `data_out` = 0 when `ce` = 0.
  - DATA read returns, per bit, the debounced input if CONFIG = 1, else `out_reg`; bits with ENABLE = 0 read 0.
  - `reg_addr` 5..7 reads 0.
- Input path:
  - 2-flop synchronizer on `port_io`, then the filter.
  - Latency from pad edge to DATA visibility: 2 cycles without the filter.
  - With the filter: 2 cycles plus `DEB_SAMPLES` ticks, rounded up to the next tick.
- Edge detect and interrupt:
  - `prev` register holds the last debounced value.
  - `rise[i]` = debounced[i] & ~prev[i] & CONFIG[i] & ENABLE[i].
  - A rise sets IRQ_STATUS[i] on the next edge.
  - Set and a W1C clear in the same cycle: set wins.
  - `irq` = OR over (IRQ_STATUS & IRQ_EN), registered, asserted the cycle after status sets.
- Reconfiguration:
  - Changing CONFIG from 1 to 0 starts driving on the next cycle.
  - Edge detection for that bit stops immediately; already-set status bits are retained.

Optional Feature:
- Macro: `PORT_DEBOUNCE_EN`.
- Defined:
  - Prescaler counts 0..`DEB_DIV`-1 and pulses `tick` on wrap.
  - Per-bit 3-bit counter increments on a tick when the synced bit differs from the debounced bit, and resets to 0 when they are equal.
  - On reaching `DEB_SAMPLES` the debounced bit toggles and the counter clears.
- Undefined: debounced = synchronizer output; prescaler and counters not instantiated.

Decomposition:
- Package `port_pkg`:
  - register address constants: `ADDR_DATA`, `ADDR_CONFIG`, `ADDR_ENABLE`, `ADDR_IRQ_EN`, `ADDR_IRQ_STATUS`.
  - `CONFIG` reset constant (all ones).
- Sub-module `port_debounce_bit`, instantiated per bit under a generate loop:
  - inputs: `sys_clk`, `rst_n`, `tick`, `din`.
  - output: `dout`.

Test Plan:
- Reset: hold `rst_n` = 0 for 50 ns with external drivers Z -> `port_io` all Z, `irq` = 0, CONFIG reads 0xFFFFFFFF, DATA reads 0.
- Output drive:
  - Write CONFIG = 0xFFFFFFF8, ENABLE = 0x7, DATA = 0x5 -> `port_io[2:0]` = 3'b101 on the next edge, `port_io[31:3]` Z.
  - DATA reads 0x5.
- Input sample (macro undefined):
  - ENABLE = 0x7, CONFIG all ones, drive `port_io[2:0]` = 3'b100 -> DATA reads 0x4 exactly 2 cycles later.
- Interrupt:
  - With IRQ_EN = 0x4, drive bit 2 from 0 to 1 -> IRQ_STATUS = 0x4 and `irq` = 1 one cycle after it.
  - Write IRQ_STATUS = 0x4 -> `irq` = 0.
  - Simultaneous new rise and clear -> status stays 1.
- Debounce (macro defined, `DEB_DIV` = 4):
  - Bit 0 toggles 1/0 every 6 cycles -> DATA bit 0 stays 0.
  - Bit 0 held 1 for 20 cycles -> reads 1 after at most 2 + 3×4 + 4 cycles.
- Disabled bits:
  - ENABLE = 0, drive `port_io[1]` = 1 -> DATA reads 0, no IRQ_STATUS set.
  - `reg_addr` = 6 read -> 0.
